// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves both source operands through the EX/MEM/WB
// bypass network, detects load-use hazards against the instruction held in
// the output register, and registers one operand bundle for the ALU stage.
//
// Ports (summary):
//   clk, reset              clock, synchronous active-high reset
//   in_*                    decoded fields, aligned with rdata1/rdata2
//   rdata1, rdata2          register-bank read data
//   ex_fwd_* / mem_fwd_*    EX and MEM result bypasses
//   wb_write/wb_dr/wb_data  register-bank write committing this cycle
//   ex_stall, flush         downstream hold / kill
//   stall_req               combinational upstream hold
//   out_*                   registered operand bundle
//   bubble_cnt, fwd_cnt     saturating performance counters

// One operand's bypass mux. r0 always reads zero and is never bypassed.
module id_ex_fwd_mux #(
  parameter int DW = 32
) (
  input  logic [4:0]    src,
  input  logic [DW-1:0] rdata,
  input  logic          ex_fwd_en,
  input  logic [4:0]    ex_fwd_dr,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          mem_fwd_en,
  input  logic [4:0]    mem_fwd_dr,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_write,
  input  logic [4:0]    wb_dr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] opnd,
  output logic          bypassed
);
  always_comb begin
    opnd     = rdata;
    bypassed = 1'b1;
    if (src == 5'd0) begin
      opnd     = '0;
      bypassed = 1'b0;
    end else if (ex_fwd_en && ex_fwd_dr == src) begin
      opnd = ex_fwd_data;
    end else if (mem_fwd_en && mem_fwd_dr == src) begin
      opnd = mem_fwd_data;
    end else if (wb_write && wb_dr == src) begin
      // bank reads before it writes, so the committing value is bypassed
      opnd = wb_data;
    end else begin
      bypassed = 1'b0;
    end
  end
endmodule

module id_ex_operand_stage #(
  parameter int DW  = 32,
  parameter int CW  = 8,
  parameter int PCW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [4:0]    in_sr1,
  input  logic [4:0]    in_sr2,
  input  logic [4:0]    in_dr,
  input  logic          in_wb_en,
  input  logic          in_is_load,
  input  logic [DW-1:0] in_imm,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic          ex_fwd_en,
  input  logic [4:0]    ex_fwd_dr,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          mem_fwd_en,
  input  logic [4:0]    mem_fwd_dr,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_write,
  input  logic [4:0]    wb_dr,
  input  logic [DW-1:0] wb_data,
  input  logic          ex_stall,
  input  logic          flush,
  output logic          stall_req,
  output logic          out_valid,
  output logic [DW-1:0] out_op1,
  output logic [DW-1:0] out_op2,
  output logic [DW-1:0] out_imm,
  output logic [4:0]    out_dr,
  output logic          out_wb_en,
  output logic          out_is_load,
  output logic [CW-1:0] out_ctrl,
  output logic [PCW-1:0] bubble_cnt,
  output logic [PCW-1:0] fwd_cnt
);
  localparam int NUM_OPS = 2;
  localparam logic [PCW-1:0] CNT_MAX = '1;

  logic [NUM_OPS-1:0][4:0]    src;
  logic [NUM_OPS-1:0][DW-1:0] rdata;
  logic [NUM_OPS-1:0][DW-1:0] opnd;
  logic [NUM_OPS-1:0]         byp;
  logic                       hazard;

  assign src   = {in_sr2, in_sr1};
  assign rdata = {rdata2, rdata1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    id_ex_fwd_mux #(.DW(DW)) u_mux (
      .src          (src[i]),
      .rdata        (rdata[i]),
      .ex_fwd_en    (ex_fwd_en),
      .ex_fwd_dr    (ex_fwd_dr),
      .ex_fwd_data  (ex_fwd_data),
      .mem_fwd_en   (mem_fwd_en),
      .mem_fwd_dr   (mem_fwd_dr),
      .mem_fwd_data (mem_fwd_data),
      .wb_write     (wb_write),
      .wb_dr        (wb_dr),
      .wb_data      (wb_data),
      .opnd         (opnd[i]),
      .bypassed     (byp[i])
    );
  end

  // A load still in the output register has no EX result to bypass yet;
  // one bubble lets it reach MEM, where the MEM bypass picks it up.
  assign hazard = in_valid && out_valid && out_is_load && out_wb_en &&
                  (out_dr != 5'd0) && (out_dr == in_sr1 || out_dr == in_sr2);

  assign stall_req = !reset && (hazard || ex_stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_dr      <= '0;
      out_wb_en   <= 1'b0;
      out_is_load <= 1'b0;
      out_ctrl    <= '0;
      bubble_cnt  <= '0;
      fwd_cnt     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ex_stall) begin
      // hold everything
    end else if (hazard) begin
      out_valid <= 1'b0;
      if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_op1     <= opnd[0];
        out_op2     <= opnd[1];
        out_imm     <= in_imm;
        out_dr      <= in_dr;
        out_wb_en   <= in_wb_en;
        out_is_load <= in_is_load;
        out_ctrl    <= in_ctrl;
        if (|byp && fwd_cnt != CNT_MAX) fwd_cnt <= fwd_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the register bank's read ports.
- Takes the decoded instruction fields plus the two register-bank read values.
- Resolves data hazards by forwarding from EX, MEM and WB, and detects load-use hazards.
- Presents one registered, hazard-free operand bundle to the ALU stage, with stall, flush and bubble accounting.

Parameters:
- DW, 32, operand and immediate width.
- CW, 8, width of the opaque control bundle passed through to EX.
- PCW, 16, width of the bubble and forward performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decoded instruction present; fields below are aligned with rdata1/rdata2 this cycle.
- in_sr1, in_sr2, in_dr  in  5 each  source and destination register indices.
- in_wb_en  in  1  instruction writes in_dr.
- in_is_load  in  1  instruction is a load; its result is available only from MEM.
- in_imm  in  DW  sign-extended immediate.
- in_ctrl  in  CW  ALU/branch control, passed through unchanged.
- rdata1, rdata2  in  DW  register-bank read data for in_sr1/in_sr2.
- ex_fwd_en, ex_fwd_dr, ex_fwd_data  in  1/5/DW  EX-stage result bypass.
- mem_fwd_en, mem_fwd_dr, mem_fwd_data  in  1/5/DW  MEM-stage result bypass.
- wb_write, wb_dr, wb_data  in  1/5/DW  write being committed to the register bank this cycle.
- ex_stall  in  1  downstream cannot accept; hold the output register.
- flush  in  1  kill the instruction being captured and the one held in the output.
- stall_req  out  1  combinational; upstream must hold its fields this cycle.
- out_valid  out  1  output bundle valid.
- out_op1, out_op2, out_imm  out  DW each  resolved operands and immediate.
- out_dr, out_wb_en, out_is_load, out_ctrl  out  5/1/1/CW  registered copies of the inputs.
- bubble_cnt, fwd_cnt  out  PCW each  saturating performance counters.

Behaviour:
- Reset (synchronous):
  - out_valid=0.
  - All out_* data fields = 0.
  - bubble_cnt = fwd_cnt = 0.
  - stall_req is forced to 0 while reset is high.
- Operand resolution (combinational, per source s in {sr1, sr2}), priority highest first:
  1. s==0 -> 0. r0 is never forwarded.
  2. ex_fwd_en && ex_fwd_dr==s -> ex_fwd_data.
  3. mem_fwd_en && mem_fwd_dr==s -> mem_fwd_data.
  4. wb_write && wb_dr==s -> wb_data. This covers the register-bank read-before-write case.
  5. Otherwise rdata.
- Load-use hazard:
  - hazard = in_valid && out_valid && out_is_load && out_wb_en && out_dr!=0 && (out_dr==in_sr1 || out_dr==in_sr2).
  - stall_req = hazard || ex_stall.
- Register update on each posedge, precedence reset > flush > ex_stall > hazard > load:
  - flush: out_valid<=0; data fields unchanged; stall_req is ignored that cycle.
  - ex_stall: all outputs hold.
  - hazard: bubble inserted; out_valid<=0; bubble_cnt increments.
  - Otherwise: out_valid<=in_valid; if in_valid, capture the resolved operands and all fields.
- Latency: exactly one cycle from in_valid to out_valid when there is no hazard or stall.
- A hazard costs exactly one bubble. On the next cycle the load is no longer in the output register and forwarding comes from MEM.
- fwd_cnt increments once per accepted instruction for which at least one operand took a bypass path (priority 2-4).
- Both counters saturate at 2^PCW-1 and do not wrap.
- in_valid=0 with no stall/flush -> out_valid<=0 and data fields are don't-care, held.
- Both sources equal the same forwarded dr -> both operands receive the same value.
- out_dr==0 load -> no hazard.

Test Plan:
- Reset mid-stream: out_valid=1 with out_op1=0x1234, then reset for one cycle -> out_valid=0, out_op1=0, counters 0, stall_req=0.
- Priority: in_sr1=5, ex_fwd(5,0xAAAA), mem_fwd(5,0xBBBB), wb(5,0xCCCC), rdata1=0x1 -> out_op1=0xAAAA. Drop EX -> 0xBBBB. Drop MEM -> 0xCCCC. Drop WB -> 0x1. fwd_cnt=3.
- r0: in_sr2=0, ex_fwd(0,0xFFFF), rdata2=0x77 -> out_op2=0. fwd_cnt unchanged.
- Load-use: load dr=7 in output, next in_sr1=7 -> stall_req=1, next out_valid=0, bubble_cnt=1. Following cycle with mem_fwd(7,0x55) -> out_op1=0x55, out_valid=1.
- ex_stall held 3 cycles with a changing input -> outputs frozen, stall_req=1 each cycle.
- flush together with hazard and ex_stall -> out_valid=0 next cycle; bubble_cnt not incremented.
- Saturation, PCW=2: 5 consecutive load-use bubbles -> bubble_cnt=3.
